// File: rtl/axis_pkg.sv
// Shared defaults and FSM encoding for the AXI-Stream packet generator.
package axis_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI-Stream burst generator: emits num_pkts packets of pkt_len beats with an
// incrementing data pattern starting at seed, separated by gap idle cycles.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int GAP_W  = DEF_GAP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [7:0]        num_pkts,
  input  logic [GAP_W-1:0]  gap,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [7:0]         r_npkts;
  logic [GAP_W-1:0]   r_gap;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [7:0]         r_pkt_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic               w_xfer;
  logic [LEN_W-1:0]   w_beat_nxt;
  logic [LEN_W-1:0]   w_len_m1;
  logic               w_final_pkt;

  assign w_xfer      = m_valid && m_ready;
  assign w_beat_nxt  = r_beat_cnt + LEN_W'(1);
  assign w_len_m1    = r_len - LEN_W'(1);
  assign w_final_pkt = (r_pkt_cnt == (r_npkts - 8'd1));

  // Burst FSM with counters; every output is a flop so m_ready never reaches
  // m_valid/m_data/m_last through logic.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_npkts    <= '0;
      r_gap      <= '0;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_gap_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len      <= pkt_len;
            r_npkts    <= num_pkts;
            r_gap      <= gap;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
            busy       <= 1'b1;
            if (pkt_len == '0 || num_pkts == '0) begin
              // Empty burst: straight to FIN, no beats.
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              r_state <= SEND;
              m_data  <= seed;
              m_valid <= 1'b1;
              m_last  <= (pkt_len == LEN_W'(1));
            end
          end
        end

        SEND: begin
          if (w_xfer) begin
            // Data keeps counting across packet boundaries.
            m_data <= m_data + DATA_W'(1);
            if (m_last) begin
              r_beat_cnt <= '0;
              if (w_final_pkt) begin
                r_state <= FIN;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
                if (r_gap == '0) begin
                  // Back-to-back packet: valid stays high, no bubble.
                  m_last <= (r_len == LEN_W'(1));
                end else begin
                  r_state   <= GAP;
                  m_valid   <= 1'b0;
                  m_last    <= 1'b0;
                  r_gap_cnt <= r_gap - GAP_W'(1);
                end
              end
            end else begin
              r_beat_cnt <= w_beat_nxt;
              m_last     <= (w_beat_nxt == w_len_m1);
            end
          end
        end

        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= SEND;
            m_valid <= 1'b1;
            m_last  <= (r_len == LEN_W'(1));
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end

        FIN: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed self-checking bench for axis_pkt_gen.
module tb_axis_pkt_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pkt_len;
  logic [7:0] num_pkts;
  logic [3:0] gap;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  int n_pass  = 0;
  int n_total = 0;

  axis_pkt_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pkt_len  (pkt_len),
    .num_pkts (num_pkts),
    .gap      (gap),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then scramble config to show it is not re-read.
  task automatic launch(input logic [7:0] len, input logic [7:0] n,
                        input logic [3:0] g, input logic [7:0] s);
    pkt_len  = len;
    num_pkts = n;
    gap      = g;
    seed     = s;
    start    = 1'b1;
    step();
    start    = 1'b0;
    pkt_len  = 8'h55;
    num_pkts = 8'h77;
    gap      = 4'h9;
    seed     = 8'hC3;
  endtask

  // Expect a presented beat (m_ready assumed 1), then let it transfer.
  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_data"},  32'(m_data),  32'(d));
    check({tag, "_last"},  32'(m_last),  32'(l));
    check({tag, "_busy"},  32'(busy),    32'd1);
    step();
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_fin_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_fin_done"},  32'(done),    32'd1);
    check({tag, "_fin_busy"},  32'(busy),    32'd1);
    step();
    check({tag, "_idle_done"}, 32'(done),    32'd0);
    check({tag, "_idle_busy"}, 32'(busy),    32'd0);
  endtask

  initial begin
    logic [7:0] hold_d;
    logic       hold_l;
    logic       held;
    logic       seen_done;
    int         idx;

    rst      = 1'b0;
    start    = 1'b0;
    pkt_len  = '0;
    num_pkts = '0;
    gap      = '0;
    seed     = '0;
    m_ready  = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last",  32'(m_last),  32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_done",  32'(done),    32'd0);
    rst = 1'b1;
    step();

    // Single 4-beat packet, seed 0x10
    launch(8'd4, 8'd1, 4'd0, 8'h10);
    beat("s1_b0", 8'h10, 1'b0);
    beat("s1_b1", 8'h11, 1'b0);
    beat("s1_b2", 8'h12, 1'b0);
    beat("s1_b3", 8'h13, 1'b1);
    expect_done("s1");

    // Two 3-beat packets with a 2-cycle gap, data wraps through 0xFF
    launch(8'd3, 8'd2, 4'd2, 8'hFE);
    beat("s2_p0b0", 8'hFE, 1'b0);
    beat("s2_p0b1", 8'hFF, 1'b0);
    beat("s2_p0b2", 8'h00, 1'b1);
    check("s2_gap0_valid", 32'(m_valid), 32'd0);
    check("s2_gap0_busy",  32'(busy),    32'd1);
    step();
    check("s2_gap1_valid", 32'(m_valid), 32'd0);
    step();
    beat("s2_p1b0", 8'h01, 1'b0);
    beat("s2_p1b1", 8'h02, 1'b0);
    beat("s2_p1b2", 8'h03, 1'b1);
    expect_done("s2");

    // Backpressure: m_ready pattern 1,0,0 repeating, 5 beats 00..04
    launch(8'd5, 8'd1, 4'd0, 8'h00);
    idx       = 0;
    held      = 1'b0;
    seen_done = 1'b0;
    hold_d    = '0;
    hold_l    = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      m_ready = ((c % 3) == 0);
      if (held) begin
        check("s3_stall_valid", 32'(m_valid), 32'd1);
        check("s3_stall_data",  32'(m_data),  32'(hold_d));
        check("s3_stall_last",  32'(m_last),  32'(hold_l));
      end
      if (m_valid && m_ready) begin
        check("s3_data", 32'(m_data), 32'(idx));
        check("s3_last", 32'(m_last), (idx == 4) ? 32'd1 : 32'd0);
        idx++;
      end
      held   = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      if (done) seen_done = 1'b1;
      step();
    end
    m_ready = 1'b1;
    check("s3_beats", 32'(idx), 32'd5);
    check("s3_done_seen", 32'(seen_done), 32'd1);
    check("s3_idle_busy", 32'(busy), 32'd0);

    // Empty bursts: pkt_len=0, then num_pkts=0
    launch(8'd0, 8'd3, 4'd0, 8'h40);
    expect_done("s4a");
    launch(8'd4, 8'd0, 4'd0, 8'h40);
    expect_done("s4b");

    // Single-beat packets back to back
    launch(8'd1, 8'd3, 4'd0, 8'h07);
    beat("s5_b0", 8'h07, 1'b1);
    beat("s5_b1", 8'h08, 1'b1);
    beat("s5_b2", 8'h09, 1'b1);
    expect_done("s5");

    // Second start mid-burst is ignored
    launch(8'd4, 8'd1, 4'd0, 8'h20);
    beat("s6_b0", 8'h20, 1'b0);
    beat("s6_b1", 8'h21, 1'b0);
    pkt_len = 8'd2;
    seed    = 8'h99;
    start   = 1'b1;
    beat("s6_b2", 8'h22, 1'b0);
    start   = 1'b0;
    beat("s6_b3", 8'h23, 1'b1);
    expect_done("s6");
    step();
    check("s6_no_restart", 32'(m_valid), 32'd0);

    // Reset during beat 2, then restart from seed
    launch(8'd4, 8'd1, 4'd0, 8'h30);
    beat("s7_b0", 8'h30, 1'b0);
    beat("s7_b1", 8'h31, 1'b0);
    check("s7_pre_rst_data", 32'(m_data), 32'h32);
    rst = 1'b0;
    #1;
    check("s7_rst_valid", 32'(m_valid), 32'd0);
    check("s7_rst_last",  32'(m_last),  32'd0);
    check("s7_rst_data",  32'(m_data),  32'd0);
    check("s7_rst_busy",  32'(busy),    32'd0);
    step();
    rst = 1'b1;
    launch(8'd4, 8'd1, 4'd0, 8'h30);
    beat("s7_r0", 8'h30, 1'b0);
    beat("s7_r1", 8'h31, 1'b0);
    beat("s7_r2", 8'h32, 1'b0);
    beat("s7_r3", 8'h33, 1'b1);
    expect_done("s7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
